// File: rtl/sumador_pipe.sv
// sumador_pipe: pipelined add/subtract resolving one CHUNK slice per stage; Z/N/V built only with SUMADOR_FLAGS_EN
module sumador_pipe #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Z,
  output logic             N,
  output logic             V
);
  localparam int STAGES = WIDTH / CHUNK;
  localparam int L = STAGES - 1;
  if ((WIDTH % CHUNK) != 0 || STAGES < 1) begin : g_bad_cfg
    $error("sumador_pipe: WIDTH must be a nonzero multiple of CHUNK");
  end
  logic [STAGES-1:0] v, c;
  logic [WIDTH-1:0]  r   [STAGES];
  logic [WIDTH-1:0]  b   [STAGES];
  logic [WIDTH-1:0]  nxt [STAGES];
  logic [CHUNK:0]    sum [STAGES];
  logic              adv;
  assign adv = !(out_valid && !out_ready);
  assign in_ready = adv;
  // r holds resolved low slices below the current stage and untouched A slices above it
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      sum[k] = {1'b0, r[k][k*CHUNK +: CHUNK]} + {1'b0, b[k][k*CHUNK +: CHUNK]} + (CHUNK+1)'(c[k]);
      nxt[k] = r[k];
      nxt[k][k*CHUNK +: CHUNK] = sum[k][CHUNK-1:0];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      out_valid <= 1'b0;
      S <= '0;
      Cout <= 1'b0;
    end else if (adv) begin
      v[0] <= in_valid;
      r[0] <= A;
      b[0] <= Op ? ~B : B;
      c[0] <= Cin ^ Op;
      for (int k = 1; k < STAGES; k++) begin
        v[k] <= v[k-1];
        r[k] <= nxt[k-1];
        b[k] <= b[k-1];
        c[k] <= sum[k-1][CHUNK];
      end
      out_valid <= v[L];
      if (v[L]) begin
        S <= nxt[L];
        Cout <= sum[L][CHUNK];
      end
    end
  end
`ifdef SUMADOR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      Z <= 1'b0;
      N <= 1'b0;
      V <= 1'b0;
    end else if (adv && v[L]) begin
      Z <= nxt[L] == '0;
      N <= nxt[L][WIDTH-1];
      V <= (r[L][WIDTH-1] == b[L][WIDTH-1]) && (nxt[L][WIDTH-1] != r[L][WIDTH-1]);
    end
  end
`else
  assign Z = 1'b0;
  assign N = 1'b0;
  assign V = 1'b0;
`endif
endmodule

// File: tb/tb_sumador_pipe.sv
// tb_sumador_pipe: drives 8/4 and 16/4 instances in lockstep against an integer-arithmetic scoreboard
module tb_sumador_pipe;
  typedef struct packed {logic [15:0] s; logic c; logic z; logic n; logic v;} res_t;
  typedef struct {res_t r; int t;} ent_t;
  logic clk, rst, in_valid, out_ready, cin, op;
  logic [7:0] a8, b8, s8;
  logic [15:0] a16, b16, s16;
  logic ir8, ov8, c8, z8, n8, v8;
  logic ir16, ov16, c16, z16, n16, v16;
  int checks = 0, errors = 0, cyc = 0;
  bit latchk = 0;
  ent_t q [2][$];
  res_t last [2];
  logic [7:0] da [5] = '{8'hFF, 8'h0F, 8'h7F, 8'h05, 8'h00};
  logic [7:0] db [5] = '{8'hFF, 8'h00, 8'h01, 8'h05, 8'h01};
  bit dc [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  bit dop [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  sumador_pipe #(.WIDTH(8), .CHUNK(4)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir8), .A(a8), .B(b8), .Cin(cin), .Op(op),
    .out_valid(ov8), .out_ready(out_ready), .S(s8), .Cout(c8), .Z(z8), .N(n8), .V(v8));
  sumador_pipe #(.WIDTH(16), .CHUNK(4)) u16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir16), .A(a16), .B(b16), .Cin(cin), .Op(op),
    .out_valid(ov16), .out_ready(out_ready), .S(s16), .Cout(c16), .Z(z16), .N(n16), .V(v16));

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic res_t model(input int w, input longint a, input longint b, input bit ci, input bit o);
    longint m, r, sa, sb, sr;
    res_t e;
    m = longint'(1) << w;
    r = o ? a - b - longint'(ci) : a + b + longint'(ci);
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    sr = o ? sa - sb - longint'(ci) : sa + sb + longint'(ci);
    e = '0;
    e.s = 16'(r & (m - 1));
    e.c = o ? (r >= 0) : (r >= m);
`ifdef SUMADOR_FLAGS_EN
    e.z = (e.s == 0);
    e.n = e.s[w-1];
    e.v = (sr < -(m / 2)) || (sr >= m / 2);
`endif
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic observe(input int i);
    logic ov, rdy;
    res_t o;
    ent_t e;
    string w;
    w = (i == 1) ? "_w16" : "_w8";
    ov = (i == 1) ? ov16 : ov8;
    rdy = (i == 1) ? ir16 : ir8;
    o = (i == 1) ? {s16, c16, z16, n16, v16} : {8'h00, s8, c8, z8, n8, v8};
    if (ov && q[i].size() == 0) chk({"spurious", w}, ov, 1'b0);
    else if (ov && out_ready) begin
      e = q[i].pop_front();
      chk({"result", w}, o, e.r);
      if (latchk) chk({"latency", w}, cyc - e.t, (i == 1) ? 4 : 2);
      last[i] = e.r;
    end else if (ov) begin
      chk({"stall_rdy", w}, rdy, 1'b0);
      chk({"stall_hold", w}, o, q[i][0].r);
    end else chk({"idle_hold", w}, o, last[i]);
  endtask

  task automatic step(input bit iv, input bit ordy);
    bit acc8, acc16;
    ent_t e;
    in_valid = iv;
    out_ready = ordy;
    @(negedge clk);
    observe(0);
    observe(1);
    acc8 = in_valid && ir8;
    acc16 = in_valid && ir16;
    @(posedge clk);
    cyc++;
    e.t = cyc;
    if (acc8) begin
      e.r = model(8, a8, b8, cin, op);
      q[0].push_back(e);
    end
    if (acc16) begin
      e.r = model(16, a16, b16, cin, op);
      q[1].push_back(e);
    end
    #1;
  endtask

  task automatic rnd();
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    a16 = 16'($urandom);
    b16 = 16'($urandom);
    cin = 1'($urandom);
    op = 1'($urandom);
  endtask

  task automatic do_reset();
    rst = 1;
    in_valid = 0;
    @(posedge clk);
    cyc++;
    #1;
    rst = 0;
    q[0].delete();
    q[1].delete();
    last[0] = '0;
    last[1] = '0;
    chk("rst_ov_w8", ov8, 1'b0);
    chk("rst_out_w8", {s8, c8, z8, n8, v8}, 0);
    chk("rst_rdy_w8", ir8, 1'b1);
    chk("rst_ov_w16", ov16, 1'b0);
    chk("rst_out_w16", {s16, c16, z16, n16, v16}, 0);
    chk("rst_rdy_w16", ir16, 1'b1);
  endtask

  initial begin
    rst = 1;
    in_valid = 0;
    out_ready = 1;
    a8 = 0; b8 = 0; a16 = 0; b16 = 0; cin = 0; op = 0;
    do_reset();
    latchk = 1;
    for (int j = 0; j < 5; j++) begin
      rnd();
      a8 = da[j];
      b8 = db[j];
      cin = dc[j];
      op = dop[j];
      step(1, 1);
    end
    repeat (5) step(0, 1);
    repeat (4) begin
      rnd();
      step(1, 1);
    end
    repeat (5) step(0, 1);
    latchk = 0;
    repeat (60) begin
      rnd();
      step(1'($urandom), $urandom_range(3) != 0);
    end
    repeat (8) step(0, 1);
    repeat (4) begin
      rnd();
      step(1, 1);
    end
    repeat (3) begin
      rnd();
      step(1, 0);
    end
    chk("stall_full_ov_w8", ov8, 1'b1);
    repeat (10) step(0, 1);
    chk("drain_w8", q[0].size(), 0);
    chk("drain_w16", q[1].size(), 0);
    rnd();
    step(1, 1);
    rnd();
    step(1, 1);
    do_reset();
    repeat (6) step(0, 1);
    chk("post_rst_empty_w8", q[0].size(), 0);
    chk("post_rst_empty_w16", q[1].size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
